// File: rtl/event_pkg.sv
// event_pkg: shared widths, polarity-mode encodings and event record for the
// DVS event filter.
package event_pkg;

   localparam int XW_DEF    = 8;
   localparam int YW_DEF    = 8;
   localparam int TW_DEF    = 16;
   localparam int DEPTH_DEF = 8;
   localparam int CW_DEF    = 16;

   localparam logic [1:0] MODE_ALL  = 2'b00;
   localparam logic [1:0] MODE_ON   = 2'b01;
   localparam logic [1:0] MODE_OFF  = 2'b10;
   localparam logic [1:0] MODE_NONE = 2'b11;

   typedef struct packed {
      logic [XW_DEF-1:0] x;
      logic [YW_DEF-1:0] y;
      logic [TW_DEF-1:0] t;
      logic              p;
   } event_t;

   // MODE_NONE falls through every term and so rejects all events
   function automatic logic mode_ok(input logic [1:0] mode, input logic p);
      return (mode == MODE_ALL) || (mode == MODE_ON && p) || (mode == MODE_OFF && !p);
   endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: first-word-fall-through synchronous FIFO; full/empty derive from
// the occupancy count, and the head reads as zero while empty.
module event_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign empty_o = level_q == '0;
   assign full_o  = level_q == (AW+1)'(DEPTH);
   assign level_o = level_q;
   assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

   // a full FIFO still takes a write when the head leaves in the same cycle
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
      level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/event_filter_roi.sv
// event_filter_roi: polarity-mode and rectangular ROI filter for address
// events, buffered in an FWFT FIFO with saturating reject/overflow counters.
module event_filter_roi
   import event_pkg::*;
#(
   parameter int XW    = XW_DEF,
   parameter int YW    = YW_DEF,
   parameter int TW    = TW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [XW-1:0]             in_x,
   input  logic [YW-1:0]             in_y,
   input  logic [TW-1:0]             in_t,
   input  logic                      in_p,
   input  logic [1:0]                cfg_mode,
   input  logic [XW-1:0]             cfg_x_min,
   input  logic [XW-1:0]             cfg_x_max,
   input  logic [YW-1:0]             cfg_y_min,
   input  logic [YW-1:0]             cfg_y_max,
   input  logic                      cnt_clr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XW-1:0]             out_x,
   output logic [YW-1:0]             out_y,
   output logic [TW-1:0]             out_t,
   output logic                      out_p,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [CW-1:0]             filt_count,
   output logic [CW-1:0]             ovf_count
);

   localparam int EW = XW + YW + TW + 1;

   logic          stg_valid_q, stg_valid_d;
   logic          stg_pass_q, stg_pass_d;
   logic [EW-1:0] stg_ev_q, stg_ev_d;
   logic [CW-1:0] filt_q, filt_d, ovf_q, ovf_d;
   logic          pass, push, pop, fifo_full, fifo_empty, filt_inc, ovf_inc;

   assign in_ready = 1'b1;

   // an inverted window (min > max) fails one of the two bounds for every address
   assign pass = mode_ok(cfg_mode, in_p)
              && in_x >= cfg_x_min && in_x <= cfg_x_max
              && in_y >= cfg_y_min && in_y <= cfg_y_max;

   always_comb begin
      stg_valid_d = in_valid;
      stg_pass_d  = in_valid ? pass : stg_pass_q;
      stg_ev_d    = in_valid ? {in_x, in_y, in_t, in_p} : stg_ev_q;
   end

   assign push     = stg_valid_q && stg_pass_q;
   assign pop      = out_valid && out_ready;
   assign filt_inc = stg_valid_q && !stg_pass_q;
   assign ovf_inc  = push && fifo_full && !pop;

   always_comb begin
      filt_d = cnt_clr ? '0 : (filt_inc && filt_q != '1) ? filt_q + 1'b1 : filt_q;
      ovf_d  = cnt_clr ? '0 : (ovf_inc && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_valid_q <= 1'b0;
         stg_pass_q  <= 1'b0;
         stg_ev_q    <= '0;
         filt_q      <= '0;
         ovf_q       <= '0;
      end else begin
         stg_valid_q <= stg_valid_d;
         stg_pass_q  <= stg_pass_d;
         stg_ev_q    <= stg_ev_d;
         filt_q      <= filt_d;
         ovf_q       <= ovf_d;
      end
   end

   event_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (stg_ev_q),
      .pop_i   (pop),
      .dout_o  ({out_x, out_y, out_t, out_p}),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign out_valid  = !fifo_empty;
   assign filt_count = filt_q;
   assign ovf_count  = ovf_q;

endmodule

// File: tb/tb_event_filter_roi.sv
// tb_event_filter_roi: directed steps with a scoreboard queue of expected
// output events, checked in order as the DUT hands them downstream.
module tb_event_filter_roi;
   import event_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [7:0]  in_x = '0, in_y = '0;
   logic [15:0] in_t = '0;
   logic        in_p = 1'b0;
   logic [1:0]  cfg_mode = MODE_ALL;
   logic [7:0]  cfg_x_min = 8'd0, cfg_x_max = 8'd255, cfg_y_min = 8'd0, cfg_y_max = 8'd255;
   logic        cnt_clr = 1'b0;
   logic        out_valid, out_ready = 1'b0;
   logic [7:0]  out_x, out_y;
   logic [15:0] out_t;
   logic        out_p;
   logic [3:0]  fifo_level;
   logic [3:0]  filt_count, ovf_count;

   int     vectors = 0;
   int     miscompares = 0;
   event_t sb[$];

   always #5 clk = ~clk;

   event_filter_roi #(.XW(8), .YW(8), .TW(16), .DEPTH(8), .CW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_t(in_t), .in_p(in_p), .cfg_mode(cfg_mode),
      .cfg_x_min(cfg_x_min), .cfg_x_max(cfg_x_max), .cfg_y_min(cfg_y_min), .cfg_y_max(cfg_y_max),
      .cnt_clr(cnt_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_t(out_t), .out_p(out_p),
      .fifo_level(fifo_level), .filt_count(filt_count), .ovf_count(ovf_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] t,
                       input logic p, input logic exp);
      in_valid = 1'b1; in_x = x; in_y = y; in_t = t; in_p = p;
      if (exp) sb.push_back('{x: x, y: y, t: t, p: p});
      step();
   endtask

   task automatic clear_counters();
      in_valid = 1'b0;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
         else chk("out_event", {31'd0, out_x, out_y, out_t, out_p}, {31'd0, sb.pop_front()});
      end
   end

   initial begin
      // reset and idle
      #12 rst_n = 1'b1;
      idle(2);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_fields", {out_x, out_y, out_t, out_p}, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_filt", filt_count, 0);
      chk("rst_ovf", ovf_count, 0);
      chk("in_ready", in_ready, 1);

      // ON-only mode, full ROI, alternating polarity, 2-cycle latency
      cfg_mode = MODE_ON;
      out_ready = 1'b1;
      send(8'd1, 8'd1, 16'd10, 1'b1, 1'b1);
      chk("lat_not_yet", out_valid, 0);
      send(8'd2, 8'd2, 16'd11, 1'b0, 1'b0);
      chk("lat_valid", out_valid, 1);
      chk("lat_head_p", out_p, 1);
      send(8'd3, 8'd3, 16'd12, 1'b1, 1'b1);
      send(8'd4, 8'd4, 16'd13, 1'b0, 1'b0);
      idle(4);
      chk("on_filt", filt_count, 2);
      chk("on_sb_drained", sb.size(), 0);

      // ROI window x 10..20, y 5..5
      cfg_mode = MODE_ALL;
      cfg_x_min = 8'd10; cfg_x_max = 8'd20; cfg_y_min = 8'd5; cfg_y_max = 8'd5;
      clear_counters();
      send(8'd9,  8'd5, 16'd20, 1'b1, 1'b0);
      send(8'd10, 8'd5, 16'd21, 1'b0, 1'b1);
      send(8'd20, 8'd5, 16'd22, 1'b1, 1'b1);
      send(8'd21, 8'd5, 16'd23, 1'b0, 1'b0);
      send(8'd15, 8'd6, 16'd24, 1'b1, 1'b0);
      idle(4);
      chk("roi_filt", filt_count, 3);
      chk("roi_sb_drained", sb.size(), 0);

      // inverted x window rejects everything
      cfg_x_min = 8'd30; cfg_x_max = 8'd20;
      clear_counters();
      send(8'd15, 8'd5, 16'd30, 1'b1, 1'b0);
      send(8'd25, 8'd5, 16'd31, 1'b0, 1'b0);
      send(8'd30, 8'd5, 16'd32, 1'b1, 1'b0);
      idle(3);
      chk("empty_roi_filt", filt_count, 3);
      chk("empty_roi_level", fifo_level, 0);

      // overflow: 10 passing events into a stalled 8-deep FIFO
      cfg_x_min = 8'd0; cfg_x_max = 8'd255; cfg_y_min = 8'd0; cfg_y_max = 8'd255;
      out_ready = 1'b0;
      clear_counters();
      for (int i = 0; i < 10; i++)
         send(8'(i + 1), 8'(2 * i), 16'(100 + i), i[0], i < 8);
      idle(2);
      chk("ovf_level", fifo_level, 8);
      chk("ovf_count", ovf_count, 2);
      chk("ovf_filt", filt_count, 0);
      chk("ovf_head", {out_x, out_t}, {8'd1, 16'd100});
      idle(3);
      chk("ovf_head_stable", {out_x, out_y, out_t, out_p}, {8'd1, 8'd0, 16'd100, 1'b0});

      // full FIFO with continuous input and continuous drain holds level 8
      send(8'd50, 8'd50, 16'd500, 1'b1, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(8'(60 + i), 8'(70 + i), 16'(600 + i), i[1], 1'b1);
         chk("steady_level", fifo_level, 8);
      end
      chk("steady_ovf", ovf_count, 2);
      idle(20);
      chk("drain_level", fifo_level, 0);
      chk("drain_sb", sb.size(), 0);
      chk("drain_out_valid", out_valid, 0);

      // 4-bit filter counter saturates, and clear beats a coincident reject
      cfg_mode = MODE_NONE;
      clear_counters();
      for (int i = 0; i < 20; i++) send(8'(i), 8'(i), 16'(i), i[0], 1'b0);
      idle(2);
      chk("sat_filt", filt_count, 15);
      send(8'd1, 8'd1, 16'd1, 1'b1, 1'b0);
      in_valid = 1'b0;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_wins", filt_count, 0);
      idle(2);
      chk("clr_hold", filt_count, 0);

      // asynchronous reset with three events buffered
      cfg_mode = MODE_ALL;
      out_ready = 1'b0;
      send(8'd7, 8'd7, 16'd7, 1'b1, 1'b0);
      send(8'd8, 8'd8, 16'd8, 1'b0, 1'b0);
      send(8'd9, 8'd9, 16'd9, 1'b1, 1'b0);
      idle(2);
      chk("pre_rst_level", fifo_level, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_level", fifo_level, 0);
      chk("async_fields", {out_x, out_y, out_t, out_p}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);
      chk("post_rst_level", fifo_level, 0);
      chk("post_rst_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
